// File: rtl/ifetch_bus_arbiter.sv
// Round-robin arbiter sharing one instruction-fetch bus between NUM_REQ requesters.
// Locks a stalled request until granted and routes in-order responses back via an ID FIFO.
module ifetch_bus_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      err_o,
  output logic                      instr_req_o,
  output logic [ADDR_W-1:0]         instr_addr_o,
  input  logic                      instr_gnt_i,
  input  logic                      instr_rvalid_i,
  input  logic [DATA_W-1:0]         instr_rdata_i,
  input  logic                      instr_err_i,
  output logic                      protocol_err_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [IW-1:0] REQ_LAST = IW'(NUM_REQ - 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t        r_state;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_rr_ptr;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_perr;

  logic [2*NUM_REQ-1:0] w_req_rot;
  logic [IW-1:0]        w_off;
  logic [IW-1:0]        w_winner;
  logic [IW-1:0]        w_sel;
  logic [IW-1:0]        w_head;
  logic                 w_grant;
  logic                 w_accept;

  // Rotate so the search starts at r_rr_ptr; the lowest set bit of the rotated vector wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_req_rot = {req_i, req_i} >> r_rr_ptr;
    w_off     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_rot[i]) w_off = IW'(i);
    end
    w_winner = IW'((int'(r_rr_ptr) + int'(w_off)) % NUM_REQ);
  end

  assign w_sel       = (r_state == LOCKED) ? r_owner : w_winner;
  assign instr_req_o = ~rst & ((r_state == LOCKED) | ((|req_i) & (r_count < MAX_CNT)));
  assign w_grant     = instr_req_o & instr_gnt_i;
  assign w_accept    = ~rst & instr_rvalid_i & (r_count != '0);
  assign w_head      = r_fifo[r_rd_ptr];

  always_comb begin
    instr_addr_o = '0;
    gnt_o        = '0;
    rvalid_o     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst && w_sel == IW'(i)) instr_addr_o = addr_i[i*ADDR_W +: ADDR_W];
      gnt_o[i]    = w_grant & (w_sel == IW'(i));
      rvalid_o[i] = w_accept & (w_head == IW'(i));
    end
  end

  assign rdata_o        = w_accept ? instr_rdata_i : '0;
  assign err_o          = w_accept & instr_err_i;
  assign protocol_err_o = r_perr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= UNLOCKED;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_perr   <= 1'b0;
    end else begin
      if (r_state == UNLOCKED && instr_req_o && !instr_gnt_i) begin
        r_state <= LOCKED;
        r_owner <= w_winner;
      end else if (w_grant) begin
        r_state <= UNLOCKED;
      end
      if (w_grant) begin
        r_rr_ptr <= (w_sel == REQ_LAST) ? '0 : w_sel + 1'b1;
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_accept) r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_grant, w_accept})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (instr_rvalid_i && r_count == '0) r_perr <= 1'b1;
    end
  end

  // NOTE: the ID storage is not reset; r_count and the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_grant) r_fifo[r_wr_ptr] <= w_sel;
  end

endmodule

// File: tb/tb_ifetch_bus_arbiter.sv
// Self-checking bench: directed scenarios then random traffic, all checked against a
// queue-based model of the arbitration, lock, and in-order response rules.
module tb_ifetch_bus_arbiter;

  localparam int NR = 2;
  localparam int MX = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_i;
  logic [NR*AW-1:0]   addr_i;
  logic [NR-1:0]      gnt_o;
  logic [NR-1:0]      rvalid_o;
  logic [DW-1:0]      rdata_o;
  logic               err_o;
  logic               instr_req_o;
  logic [AW-1:0]      instr_addr_o;
  logic               instr_gnt_i;
  logic               instr_rvalid_i;
  logic [DW-1:0]      instr_rdata_i;
  logic               instr_err_i;
  logic               protocol_err_o;

  ifetch_bus_arbiter #(
    .NUM_REQ(NR), .MAX_OUTSTANDING(MX), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of issuer IDs in grant order, pending locked requester, rr pointer.
  int      m_q[$];
  bit      m_lock  = 1'b0;
  int      m_owner = 0;
  int      m_rr    = 0;
  bit      m_perr  = 1'b0;
  logic [NR-1:0] last_gnt;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [NR*AW-1:0] av(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    return {a1, a0};
  endfunction

  // Drive one cycle of inputs after the falling edge, check outputs, then advance the model.
  task automatic step(input bit r, input logic [NR-1:0] rq, input logic [NR*AW-1:0] ad,
                      input bit g, input bit rv, input logic [DW-1:0] rd, input bit er);
    int            sel;
    bit            found;
    bit            e_req;
    bit            acc;
    logic [NR-1:0] e_gnt;
    logic [NR-1:0] e_rv;
    rst = r; req_i = rq; addr_i = ad; instr_gnt_i = g;
    instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = er;
    #1;
    sel = 0; found = 1'b0; e_req = 1'b0;
    if (!r) begin
      if (m_lock) begin
        sel   = m_owner;
        e_req = 1'b1;
      end else begin
        for (int k = 0; k < NR; k++) begin
          if (!found && rq[(m_rr + k) % NR]) begin
            found = 1'b1;
            sel   = (m_rr + k) % NR;
          end
        end
        e_req = found && (m_q.size() < MX);
      end
    end
    e_gnt = (e_req && g) ? (NR'(1) << sel) : '0;
    acc   = !r && rv && (m_q.size() > 0);
    e_rv  = acc ? (NR'(1) << m_q[0]) : '0;
    check("instr_req", instr_req_o, e_req);
    if (e_req) check("instr_addr", instr_addr_o, ad[sel*AW +: AW]);
    check("gnt", gnt_o, e_gnt);
    check("rvalid", rvalid_o, e_rv);
    if (acc) begin
      check("rdata", rdata_o, rd);
      check("err", err_o, er);
    end
    check("protocol_err", protocol_err_o, m_perr);
    check("count", dut.r_count, m_q.size());
    last_gnt = e_gnt;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_lock = 1'b0; m_owner = 0; m_rr = 0; m_perr = 1'b0;
    end else begin
      if (rv && m_q.size() == 0) m_perr = 1'b1;
      if (acc) void'(m_q.pop_front());
      if (e_req && g) begin
        m_q.push_back(sel);
        m_rr   = (sel + 1) % NR;
        m_lock = 1'b0;
      end else if (e_req && !m_lock) begin
        m_lock  = 1'b1;
        m_owner = sel;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, '0, '0, 0, 0, '0, 0);
  endtask

  task automatic drain();
    repeat (m_q.size()) step(0, '0, '0, 0, 1, DW'($urandom), 0);
  endtask

  bit            pend [NR];
  logic [AW-1:0] paddr [NR];

  initial begin
    rst = 1'b1; req_i = '0; addr_i = '0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    step(1, '0, '0, 0, 0, '0, 0);
    idle();

    // Single requester, immediate grant, response two cycles later
    step(0, 2'b01, av(0, 32'h100), 1, 0, '0, 0);
    idle();
    step(0, 2'b00, '0, 0, 1, 32'hDEAD_BEEF, 0);
    idle();

    // Move the rr pointer back to 0, then stall with both requesting
    step(0, 2'b10, av(32'h180, 0), 1, 0, '0, 0);
    drain();
    repeat (3) step(0, 2'b11, av(32'h2A0, 32'h1A0), 0, 0, '0, 0);
    step(0, 2'b11, av(32'h2A0, 32'h1A0), 1, 0, '0, 0);
    step(0, 2'b10, av(32'h2A0, 0), 1, 0, '0, 0);
    drain();

    // Round-robin with a full outstanding window, then release by one response
    repeat (3) step(0, 2'b11, av(32'h400, 32'h500), 1, 0, '0, 0);
    step(0, 2'b11, av(32'h400, 32'h500), 1, 1, 32'h0BAD_F00D, 0);
    step(0, 2'b11, av(32'h400, 32'h500), 1, 0, '0, 0);
    drain();

    // Response routing in issue order, error on the second response
    step(0, 2'b10, av(32'h200, 0), 1, 0, '0, 0);
    step(0, 2'b01, av(0, 32'h300), 1, 0, '0, 0);
    step(0, 2'b00, '0, 0, 1, 32'h1111_1111, 0);
    step(0, 2'b00, '0, 0, 1, 32'h2222_2222, 1);

    // Simultaneous grant and response at count 1
    step(0, 2'b01, av(0, 32'h600), 1, 0, '0, 0);
    step(0, 2'b10, av(32'h700, 0), 1, 1, 32'h3333_3333, 0);
    step(0, 2'b00, '0, 0, 1, 32'h4444_4444, 0);
    idle();

    // Stray response, then reset while locked with one outstanding
    step(0, 2'b00, '0, 0, 1, 32'h5555_5555, 0);
    idle();
    idle();
    step(0, 2'b01, av(0, 32'h800), 1, 0, '0, 0);
    step(0, 2'b10, av(32'h900, 0), 0, 0, '0, 0);
    step(1, 2'b10, av(32'h900, 0), 0, 0, '0, 0);
    idle();
    step(0, 2'b00, '0, 0, 1, 32'h6666_6666, 0);
    idle();
    step(1, '0, '0, 0, 0, '0, 0);

    // Random traffic: requesters hold req and address until granted
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [NR-1:0]    rq;
      logic [NR*AW-1:0] ad;
      bit               rv;
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i]  = 1'b1;
          paddr[i] = $urandom & 32'hFFFF_FFFC;
        end
        rq[i]              = pend[i];
        ad[i*AW +: AW]     = paddr[i];
      end
      rv = (m_q.size() > 0) ? ($urandom % 2 == 0) : ($urandom % 64 == 0);
      step(($urandom % 200) == 0, rq, ad, ($urandom % 3) != 0, rv, DW'($urandom), ($urandom % 4) == 0);
      for (int i = 0; i < NR; i++) if (last_gnt[i]) pend[i] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
